// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake from the host plus the instruction
// memory write port. The loader drives the write port and byte_ready
// (master), and the host/memory side drives the byte stream (slave).
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the CPU instruction memory.
// Takes a byte stream (count byte N, then 4*N little-endian data bytes),
// writes one 32-bit word per four bytes and keeps the CPU in reset until
// the whole image is committed.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing
// XOR checksum byte over all data bytes; a mismatch aborts into ERR.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    imem_loader_if.master bus,
    output logic cpu_hold,
    output logic busy,
    output logic done,
    output logic err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_FLUSH, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t            state_reg;
    logic              byte_ready_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [31:0]       wr_data_reg;
    logic              cpu_hold_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] n_last_reg;     // N-1, index of the final word
    logic [ADDR_W-1:0] word_idx_reg;
    logic [1:0]        byte_cnt_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic        accept;
    logic [23:0] lanes;                // bytes 0..2 of the word being built

    // byte_ready comes from a register, so accept never loops back into it
    assign accept = bus.byte_valid && byte_ready_reg;

    // Low three byte lanes of the word under assembly; byte 3 goes straight
    // into wr_data together with these.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_q;

        // capture this lane's byte when it is the one arriving in DATA
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= 8'h00;
            end else if (state_reg == S_DATA && accept && byte_cnt_reg == 2'(gi)) begin
                lane_q <= bus.byte_data;
            end
        end

        assign lanes[gi*8 +: 8] = lane_q;
    end

    // Load sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            byte_ready_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            cpu_hold_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            n_last_reg     <= '0;
            word_idx_reg   <= '0;
            byte_cnt_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg      <= S_LEN;
                        byte_ready_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (bus.byte_data == 8'd0 || bus.byte_data > DEPTH_B) begin
                            state_reg      <= S_ERR;
                            byte_ready_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                        end else begin
                            n_last_reg   <= ADDR_W'(bus.byte_data - 8'd1);
                            word_idx_reg <= '0;
                            byte_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_reg     <= '0;
`endif
                            state_reg    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ bus.byte_data;
`endif
                        if (byte_cnt_reg == 2'd3) begin
                            wr_en_reg   <= 1'b1;
                            wr_addr_reg <= word_idx_reg;
                            wr_data_reg <= {bus.byte_data, lanes};
                            if (word_idx_reg == n_last_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_reg      <= S_CSUM;
`else
                                state_reg      <= S_FLUSH;
                                byte_ready_reg <= 1'b0;
`endif
                            end else begin
                                word_idx_reg <= word_idx_reg + 1'b1;
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        byte_ready_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= (bus.byte_data == csum_reg) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_FLUSH: begin
                    state_reg <= S_DONE;
                    busy_reg  <= 1'b0;
                end
                S_DONE: begin
                    if (start) begin
                        state_reg      <= S_LEN;
                        byte_ready_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        cpu_hold_reg   <= 1'b1;
                    end else begin
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state_reg      <= S_LEN;
                        byte_ready_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        err_reg        <= 1'b0;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= S_IDLE;
                    byte_ready_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_reg;
    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_addr    = wr_addr_reg;
    assign bus.wr_data    = wr_data_reg;
    assign cpu_hold       = cpu_hold_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err            = err_reg;

endmodule
